// File: rtl/if_stage.sv
// if_stage: instruction fetch with hazard stalls, a one-entry skid buffer and branch redirect.
// Requests hold address until the memory completes them; redirects mid-request drain via DISCARD.
`ifndef XLEN
`define XLEN 32
`endif
module if_stage #(
  parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [`XLEN-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcwrite,
  input  logic              ifidwrite,
  input  logic              branch_taken,
  input  logic [`XLEN-1:0]  branch_target,
  output logic              imem_req,
  output logic [`XLEN-1:0]  imem_addr,
  input  logic              imem_ready,
  input  logic [`XLEN-1:0]  imem_rdata,
  output logic [`XLEN-1:0]  instruction,
  output logic [`XLEN-1:0]  pc_id,
  output logic              valid_id
);
  typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;
  state_t state, state_nxt;
  logic [`XLEN-1:0] pc, req_addr, buf_inst, buf_pc;
  logic pend, buf_v, take;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE  ? FETCH :
                state == FETCH ? ((branch_taken && imem_req && !imem_ready) ? DISCARD : FETCH) :
                state == DISCARD ? (imem_ready ? FETCH : DISCARD) : IDLE;
  end
  // pend keeps an accepted request (and its address) alive until the memory completes it
  always_comb begin
    imem_req = (state == DISCARD) || (state == FETCH && (pend || (pcwrite && !buf_v)));
    imem_addr = pend ? req_addr : pc;
    take = imem_req && imem_ready && state == FETCH && !branch_taken;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      pend <= 1'b0;
      buf_v <= 1'b0;
      buf_inst <= NOP_INST;
      buf_pc <= '0;
      instruction <= NOP_INST;
      pc_id <= '0;
      valid_id <= 1'b0;
    end else begin
      pend <= imem_req && !imem_ready;
      if (imem_req) req_addr <= imem_addr;
      if (branch_taken) pc <= branch_target & ~`XLEN'(3);
      else if (take) pc <= pc + `XLEN'(4);
      if (branch_taken) begin
        buf_v <= 1'b0;
        instruction <= NOP_INST;
        valid_id <= 1'b0;
      end else begin
        if (ifidwrite) begin
          instruction <= buf_v ? buf_inst : take ? imem_rdata : NOP_INST;
          pc_id <= buf_v ? buf_pc : take ? imem_addr : pc_id;
          valid_id <= buf_v || take;
        end
        if (take && (buf_v || !ifidwrite)) begin
          buf_v <= 1'b1;
          buf_inst <= imem_rdata;
          buf_pc <= imem_addr;
        end else if (ifidwrite) buf_v <= 1'b0;
      end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scenario tasks with a scoreboard of expected fetch addresses.
module tb_if_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hA5A5_0000;
  logic clk = 1'b0, rst = 1'b1, pcwrite = 1'b1, ifidwrite = 1'b1, branch_taken = 1'b0, imem_ready = 1'b1;
  logic [31:0] branch_target = '0, imem_rdata, imem_addr, instruction, pc_id, exp;
  logic imem_req, valid_id;
  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  if_stage dut (
    .clk(clk), .rst(rst), .pcwrite(pcwrite), .ifidwrite(ifidwrite),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .instruction(instruction), .pc_id(pc_id), .valid_id(valid_id)
  );
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ MASK;

  task automatic test_reset();
    #1 rst = 1'b0;
    #1 checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instruction !== NOP || pc_id !== 32'h0 || valid_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h inst=%h pc_id=%h valid=%b expected 0 0 %h 0 0", imem_req, imem_addr, instruction, pc_id, valid_id, NOP);
    end
    @(negedge clk); rst = 1'b1;
    #1 checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: req=%b expected 0", imem_req); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      if (i > 0) begin
        exp = sb.pop_front(); checks++;
        if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1) begin
          errors++; $display("FAIL stream_out: inst=%h pc_id=%h valid=%b expected %h %h 1", instruction, pc_id, valid_id, exp ^ MASK, exp);
        end
      end
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_req: req=%b addr=%h expected 1 %h", imem_req, imem_addr, 32'(i * 4));
      end
      sb.push_back(32'(i * 4));
    end
  endtask

  task automatic test_stall();
    @(negedge clk); ifidwrite = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1) begin
      errors++; $display("FAIL stall_pre_out: inst=%h pc_id=%h valid=%b expected %h %h 1", instruction, pc_id, valid_id, exp ^ MASK, exp);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_req8: req=%b addr=%h expected 1 8", imem_req, imem_addr); end
    sb.push_back(32'h8);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); if (i == 1) ifidwrite = 1'b1; #1; checks++;
      if (instruction !== (32'h4 ^ MASK) || pc_id !== 32'h4 || valid_id !== 1'b1 || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold: inst=%h pc_id=%h valid=%b req=%b expected %h 4 1 0", instruction, pc_id, valid_id, imem_req, 32'h4 ^ MASK);
      end
    end
    @(negedge clk); #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1) begin
      errors++; $display("FAIL stall_release_out: inst=%h pc_id=%h valid=%b expected %h %h 1", instruction, pc_id, valid_id, exp ^ MASK, exp);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next_req: req=%b addr=%h expected 1 c", imem_req, imem_addr); end
    sb.push_back(32'hC);
  endtask

  task automatic test_branch_wait();
    @(negedge clk); imem_ready = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1) begin
      errors++; $display("FAIL wait_pre_out: inst=%h pc_id=%h valid=%b expected %h %h 1", instruction, pc_id, valid_id, exp ^ MASK, exp);
    end
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h100; #1; checks++;
    if (valid_id !== 1'b0 || instruction !== NOP || pc_id !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL wait_stall_bubble: valid=%b inst=%h pc_id=%h req=%b addr=%h expected 0 %h c 1 10", valid_id, instruction, pc_id, imem_req, imem_addr, NOP);
    end
    @(negedge clk); branch_taken = 1'b0; #1; checks++;
    if (valid_id !== 1'b0 || instruction !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++; $display("FAIL wait_discard_hold: valid=%b inst=%h req=%b addr=%h expected 0 %h 1 10", valid_id, instruction, imem_req, imem_addr, NOP);
    end
    @(negedge clk); imem_ready = 1'b1; #1; checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL wait_complete_req: req=%b addr=%h expected 1 10", imem_req, imem_addr); end
    @(negedge clk); #1; checks++;
    if (valid_id !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL wait_redirect: valid=%b req=%b addr=%h expected 0 1 100", valid_id, imem_req, imem_addr);
    end
    sb.push_back(32'h100);
  endtask

  task automatic test_branch_complete();
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h103; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL complete_pre: inst=%h pc_id=%h valid=%b addr=%h expected %h %h 1 104", instruction, pc_id, valid_id, imem_addr, exp ^ MASK, exp);
    end
    @(negedge clk); branch_taken = 1'b0; #1; checks++;
    if (valid_id !== 1'b0 || instruction !== NOP || pc_id !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      errors++; $display("FAIL complete_drop: valid=%b inst=%h pc_id=%h req=%b addr=%h expected 0 %h 100 1 100", valid_id, instruction, pc_id, imem_req, imem_addr, NOP);
    end
    sb.push_back(32'h100);
    @(negedge clk); ifidwrite = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_addr !== 32'h104) begin
      errors++; $display("FAIL complete_refetch: inst=%h pc_id=%h valid=%b addr=%h expected %h %h 1 104", instruction, pc_id, valid_id, imem_addr, exp ^ MASK, exp);
    end
  endtask

  task automatic test_branch_buffer();
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h200; #1; checks++;
    if (instruction !== (32'h100 ^ MASK) || pc_id !== 32'h100 || valid_id !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL buffer_full_hold: inst=%h pc_id=%h valid=%b req=%b expected %h 100 1 0", instruction, pc_id, valid_id, imem_req, 32'h100 ^ MASK);
    end
    @(negedge clk); branch_taken = 1'b0; ifidwrite = 1'b1; #1; checks++;
    if (valid_id !== 1'b0 || instruction !== NOP || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      errors++; $display("FAIL buffer_flush: valid=%b inst=%h req=%b addr=%h expected 0 %h 1 200", valid_id, instruction, imem_req, imem_addr, NOP);
    end
    sb.push_back(32'h200);
  endtask

  task automatic test_async_reset();
    @(negedge clk); imem_ready = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h204) begin
      errors++; $display("FAIL areset_pre: inst=%h pc_id=%h valid=%b req=%b addr=%h expected %h %h 1 1 204", instruction, pc_id, valid_id, imem_req, imem_addr, exp ^ MASK, exp);
    end
    #2 rst = 1'b0;
    #1 checks++;
    if (imem_req !== 1'b0 || valid_id !== 1'b0 || imem_addr !== 32'h0 || instruction !== NOP || pc_id !== 32'h0) begin
      errors++; $display("FAIL areset_immediate: req=%b valid=%b addr=%h inst=%h pc_id=%h expected 0 0 0 %h 0", imem_req, valid_id, imem_addr, instruction, pc_id, NOP);
    end
    @(negedge clk); rst = 1'b1; imem_ready = 1'b1; sb.delete(); #1; checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL areset_idle: req=%b expected 0", imem_req); end
    @(negedge clk); #1; checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL areset_restart: req=%b addr=%h expected 1 0", imem_req, imem_addr); end
    sb.push_back(32'h0);
    @(negedge clk); #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL areset_first_out: inst=%h pc_id=%h valid=%b addr=%h expected %h %h 1 4", instruction, pc_id, valid_id, imem_addr, exp ^ MASK, exp);
    end
    sb.push_back(32'h4);
  endtask

  task automatic test_pcwrite();
    @(negedge clk); pcwrite = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL pcwrite_block: inst=%h pc_id=%h valid=%b req=%b expected %h %h 1 0", instruction, pc_id, valid_id, imem_req, exp ^ MASK, exp);
    end
    @(negedge clk); pcwrite = 1'b1; #1; checks++;
    if (valid_id !== 1'b0 || instruction !== NOP || pc_id !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++; $display("FAIL pcwrite_resume: valid=%b inst=%h pc_id=%h req=%b addr=%h expected 0 %h 4 1 8", valid_id, instruction, pc_id, imem_req, imem_addr, NOP);
    end
    sb.push_back(32'h8);
    @(negedge clk); imem_ready = 1'b0; #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL pcwrite_out8: inst=%h pc_id=%h valid=%b addr=%h expected %h %h 1 c", instruction, pc_id, valid_id, imem_addr, exp ^ MASK, exp);
    end
    @(negedge clk); pcwrite = 1'b0; #1; checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL pcwrite_outstanding: req=%b addr=%h expected 1 c", imem_req, imem_addr); end
    @(negedge clk); imem_ready = 1'b1; #1; checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL pcwrite_complete: req=%b addr=%h expected 1 c", imem_req, imem_addr); end
    sb.push_back(32'hC);
    @(negedge clk); #1;
    exp = sb.pop_front(); checks++;
    if (instruction !== (exp ^ MASK) || pc_id !== exp || valid_id !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL pcwrite_outC: inst=%h pc_id=%h valid=%b req=%b expected %h %h 1 0", instruction, pc_id, valid_id, imem_req, exp ^ MASK, exp);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_wait();
    test_branch_complete();
    test_branch_buffer();
    test_async_reset();
    test_pcwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), meaning bubble instruction.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pcwrite  in  1  hazard unit; 0 = issue no new fetch.
REQ-006 SHALL have port ifidwrite  in  1  hazard unit; 0 = IF/ID register holds.
REQ-007 SHALL have port branch_taken  in  1  one-cycle redirect pulse from EX.
REQ-008 SHALL have port branch_target  in  `XLEN  redirect address.
REQ-009 SHALL have port imem_req  out  1  fetch request.
REQ-010 SHALL have port imem_addr  out  `XLEN  fetch address.
REQ-011 SHALL have port imem_ready  in  1  memory accepts and returns data this cycle.
REQ-012 SHALL have port imem_rdata  in  `XLEN  fetched word, valid when imem_req & imem_ready.
REQ-013 SHALL have port instruction  out  `XLEN  IF/ID instruction to decode.
REQ-014 SHALL have port pc_id  out  `XLEN  address of instruction.
REQ-015 SHALL have port valid_id  out  1  instruction is real (0 = bubble).

Function
REQ-016 SHALL use states IDLE, FETCH, DISCARD; a transaction completes in any cycle with imem_req=1 and imem_ready=1.
REQ-017 SHALL hold imem_req and imem_addr stable from assertion until completion.
REQ-018 SHALL drive imem_addr from internal pc; pc += 4 on each completed, non-discarded fetch, wrapping mod 2^XLEN.
REQ-019 IDLE -> FETCH one cycle after reset release; no request in IDLE.
REQ-020 In FETCH SHALL assert imem_req only when pcwrite=1 and skid buffer empty, or a request is already outstanding.
REQ-021 Completed data SHALL go to IF/ID (instruction=imem_rdata, pc_id=fetch addr, valid_id=1) if ifidwrite=1 and buffer empty; otherwise into the one-entry skid buffer (word + addr).
REQ-022 When ifidwrite=1 and buffer full, IF/ID SHALL load buffer contents and empty it; issuing the next request waits until the following cycle.
REQ-023 When ifidwrite=1 and nothing available, IF/ID SHALL load NOP_INST, pc_id unchanged, valid_id=0.
REQ-024 When ifidwrite=0 (no flush), instruction, pc_id, valid_id SHALL hold.
REQ-025 branch_taken=1 SHALL: load IF/ID with NOP_INST/valid_id=0 regardless of ifidwrite; clear buffer; set pc = {branch_target[XLEN-1:2],2'b00}.
REQ-026 If branch_taken with request outstanding and not completing that cycle: go DISCARD, keep old imem_addr/imem_req until completion, drop data, return to FETCH.
REQ-027 If branch_taken in completion cycle: drop data, stay FETCH, next request uses new pc.
REQ-028 branch_taken in DISCARD SHALL update pc to newest target and stay DISCARD.
REQ-029 Priority: rst > branch_taken > ifidwrite/pcwrite stall.
REQ-030 Latency: word completed at cycle N with ifidwrite=1 SHALL appear on instruction at N+1.

Reset
REQ-031 On rst=0, immediately: state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instruction=NOP_INST, pc_id=0, valid_id=0, buffer empty.
REQ-032 Reset asserted mid-transaction SHALL abandon it; no data from it reaches IF/ID.

Verification
REQ-033 Release reset, imem_ready=1, rdata=addr^32'hA5A5_0000 -> pc_id 0,4,8 with valid_id=1 on consecutive cycles.
REQ-034 ifidwrite=0 two cycles while fetch of 0x8 completes -> IF/ID holds 0x4, 0x8 buffered, imem_req=0; on release 0x8 loaded, next request 0xC.
REQ-035 imem_ready low 3 cycles at addr 0x10, branch_taken target 0x100 -> bubble, imem_addr stays 0x10 until ready, data dropped, next imem_addr 0x100.
REQ-036 branch_taken target 0x103 in completion cycle -> data dropped, next imem_addr 0x100, valid_id=0 for that cycle.
REQ-037 branch_taken with ifidwrite=0 and buffer full -> buffer cleared, IF/ID bubble, fetch resumes at target.
REQ-038 rst=0 asynchronously mid-wait -> imem_req=0, valid_id=0 before next clk edge; restart fetches RESET_PC.
